// File: rtl/eth_rx_addr_filter.sv
`default_nettype none
// ============================================================================
// Module   : eth_rx_addr_filter
// Purpose  : RX destination-MAC filter for AXI-Stream bytes. Supports a
//            unicast table and broadcast/multicast/promiscuous modes, and
//            keeps saturating accept/drop/runt counters.
// Option   : define ETH_RX_FILTER_HASH_EN to add the 64-bin multicast hash.
// Revision : 1.0 - initial release
// ============================================================================
module eth_rx_addr_filter #(
    parameter int NUM_MAC_ENTRIES = 4,
    parameter int CNT_WIDTH       = 32,
    parameter int USER_WIDTH      = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [7:0]                   in_tdata_i,
    input  logic                         in_tvalid_i,
    output logic                         in_tready_o,
    input  logic                         in_tlast_i,
    input  logic [USER_WIDTH-1:0]        in_tuser_i,
    output logic [7:0]                   out_tdata_o,
    output logic                         out_tvalid_o,
    input  logic                         out_tready_i,
    output logic                         out_tlast_o,
    output logic [USER_WIDTH-1:0]        out_tuser_o,
    input  logic [48*NUM_MAC_ENTRIES-1:0] mac_table_i,
    input  logic [NUM_MAC_ENTRIES-1:0]   mac_valid_i,
    input  logic                         promisc_i,
    input  logic                         bcast_en_i,
    input  logic                         mcast_all_i,
`ifdef ETH_RX_FILTER_HASH_EN
    input  logic [63:0]                  mcast_hash_i,
`endif
    input  logic                         cnt_clr_i,
    output logic [CNT_WIDTH-1:0]         accept_cnt_o,
    output logic [CNT_WIDTH-1:0]         drop_cnt_o,
    output logic [CNT_WIDTH-1:0]         runt_cnt_o,
    output logic [3:0]                   match_idx_o
);

    localparam logic [1:0] c_HDR      = 2'd0;
    localparam logic [1:0] c_FWD_HDR  = 2'd1;
    localparam logic [1:0] c_FWD_BODY = 2'd2;
    localparam logic [1:0] c_DROP     = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [2:0]            r_cnt;
    logic [5:0][7:0]       r_hdr;
    logic [7:0]            r_out_data;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [USER_WIDTH-1:0] r_out_user;
    logic [CNT_WIDTH-1:0]  r_accept_cnt;
    logic [CNT_WIDTH-1:0]  r_drop_cnt;
    logic [CNT_WIDTH-1:0]  r_runt_cnt;
    logic [3:0]            r_match_idx;

    logic        w_in_ready;
    logic        w_in_hs;
    logic        w_out_hs;
    logic [47:0] w_dest;
    logic        w_uc_hit;
    logic [3:0]  w_uc_idx;
    logic        w_hash_hit;
    logic        w_accept;
    logic        w_accept_inc;
    logic        w_drop_inc;
    logic        w_runt_inc;

    assign w_in_hs  = in_tvalid_i & w_in_ready;
    assign w_out_hs = r_out_valid & out_tready_i;

    // The sixth byte is still on the bus when the decision is taken.
    assign w_dest = {r_hdr[0], r_hdr[1], r_hdr[2], r_hdr[3], r_hdr[4], in_tdata_i};

    always_comb begin
        w_uc_hit = 1'b0;
        w_uc_idx = 4'd0;
        for (int k = NUM_MAC_ENTRIES - 1; k >= 0; k--) begin
            if (mac_valid_i[k] && (w_dest == mac_table_i[48*k +: 48])) begin
                w_uc_hit = 1'b1;
                w_uc_idx = 4'(k);
            end
        end
    end

`ifdef ETH_RX_FILTER_HASH_EN
    logic [5:0] w_hash_idx;
    assign w_hash_idx = w_dest[47:42] ^ w_dest[41:36] ^ w_dest[35:30] ^ w_dest[29:24]
                      ^ w_dest[23:18] ^ w_dest[17:12] ^ w_dest[11:6]  ^ w_dest[5:0];
    assign w_hash_hit = w_dest[40] & mcast_hash_i[w_hash_idx];
`else
    assign w_hash_hit = 1'b0;
`endif

    assign w_accept = promisc_i
                    | (bcast_en_i & (w_dest == 48'hFFFF_FFFF_FFFF))
                    | (mcast_all_i & w_dest[40])
                    | w_hash_hit
                    | w_uc_hit;

    assign w_runt_inc   = (r_state == c_HDR) & w_in_hs & in_tlast_i;
    assign w_accept_inc = (r_state == c_FWD_HDR) & w_out_hs & (r_cnt == 3'd6);
    assign w_drop_inc   = (r_state == c_DROP) & w_in_hs & in_tlast_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_HDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_HDR:      if (w_in_hs && !in_tlast_i && (r_cnt == 3'd5))
                            w_state_nxt = w_accept ? c_FWD_HDR : c_DROP;
            c_FWD_HDR:  if (w_accept_inc) w_state_nxt = c_FWD_BODY;
            c_FWD_BODY: if (w_out_hs && r_out_last) w_state_nxt = c_HDR;
            c_DROP:     if (w_drop_inc) w_state_nxt = c_HDR;
            default:    w_state_nxt = c_HDR;
        endcase
    end

    // Body input is held off while the output stage owns the frame's last byte.
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            c_HDR:      w_in_ready = 1'b1;
            c_FWD_HDR:  w_in_ready = 1'b0;
            c_FWD_BODY: w_in_ready = !r_out_valid | (out_tready_i & !r_out_last);
            c_DROP:     w_in_ready = 1'b1;
            default:    w_in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt       <= 3'd0;
            r_hdr       <= '0;
            r_out_data  <= 8'd0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_user  <= '0;
            r_match_idx <= 4'd0;
        end else begin
            case (r_state)
                c_HDR: begin
                    if (w_in_hs) begin
                        r_hdr[r_cnt] <= in_tdata_i;
                        if (in_tlast_i) begin
                            r_cnt <= 3'd0;
                        end else if (r_cnt == 3'd5) begin
                            if (w_accept) begin
                                r_out_valid <= 1'b1;
                                r_out_data  <= r_hdr[0];
                                r_out_last  <= 1'b0;
                                r_out_user  <= '0;
                                r_cnt       <= 3'd1;
                            end else begin
                                r_cnt <= 3'd0;
                            end
                            if (w_uc_hit) r_match_idx <= w_uc_idx;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end
                c_FWD_HDR: begin
                    if (w_out_hs) begin
                        if (r_cnt == 3'd6) begin
                            r_out_valid <= 1'b0;
                            r_cnt       <= 3'd0;
                        end else begin
                            r_out_data <= r_hdr[r_cnt];
                            r_cnt      <= r_cnt + 3'd1;
                        end
                    end
                end
                c_FWD_BODY: begin
                    if (w_in_hs) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= in_tdata_i;
                        r_out_last  <= in_tlast_i;
                        r_out_user  <= in_tuser_i;
                    end else if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end
                end
                default: begin
                    if (w_drop_inc) r_cnt <= 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_accept_cnt <= '0;
            r_drop_cnt   <= '0;
            r_runt_cnt   <= '0;
        end else if (cnt_clr_i) begin
            r_accept_cnt <= '0;
            r_drop_cnt   <= '0;
            r_runt_cnt   <= '0;
        end else begin
            if (w_accept_inc && !(&r_accept_cnt)) r_accept_cnt <= r_accept_cnt + CNT_WIDTH'(1);
            if (w_drop_inc && !(&r_drop_cnt))     r_drop_cnt   <= r_drop_cnt + CNT_WIDTH'(1);
            if (w_runt_inc && !(&r_runt_cnt))     r_runt_cnt   <= r_runt_cnt + CNT_WIDTH'(1);
        end
    end

    assign in_tready_o  = w_in_ready;
    assign out_tdata_o  = r_out_data;
    assign out_tvalid_o = r_out_valid;
    assign out_tlast_o  = r_out_last;
    assign out_tuser_o  = r_out_user;
    assign accept_cnt_o = r_accept_cnt;
    assign drop_cnt_o   = r_drop_cnt;
    assign runt_cnt_o   = r_runt_cnt;
    assign match_idx_o  = r_match_idx;

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_addr_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_rx_addr_filter
// Purpose  : Directed self-checking bench for eth_rx_addr_filter (narrow
//            counters so saturation is reachable with real frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_rx_addr_filter;

    localparam int N  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_tdata = 8'd0;
    logic          in_tvalid = 1'b0;
    logic          in_tready;
    logic          in_tlast = 1'b0;
    logic [0:0]    in_tuser = 1'b0;
    logic [7:0]    out_tdata;
    logic          out_tvalid;
    logic          out_tready = 1'b1;
    logic          out_tlast;
    logic [0:0]    out_tuser;
    logic [48*N-1:0] mac_table = '0;
    logic [N-1:0]  mac_valid = '0;
    logic          promisc = 1'b0;
    logic          bcast_en = 1'b0;
    logic          mcast_all = 1'b0;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] accept_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] runt_cnt;
    logic [3:0]    match_idx;

    eth_rx_addr_filter #(
        .NUM_MAC_ENTRIES(N),
        .CNT_WIDTH      (CW),
        .USER_WIDTH     (1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_tdata_i   (in_tdata),
        .in_tvalid_i  (in_tvalid),
        .in_tready_o  (in_tready),
        .in_tlast_i   (in_tlast),
        .in_tuser_i   (in_tuser),
        .out_tdata_o  (out_tdata),
        .out_tvalid_o (out_tvalid),
        .out_tready_i (out_tready),
        .out_tlast_o  (out_tlast),
        .out_tuser_o  (out_tuser),
        .mac_table_i  (mac_table),
        .mac_valid_i  (mac_valid),
        .promisc_i    (promisc),
        .bcast_en_i   (bcast_en),
        .mcast_all_i  (mcast_all),
        .cnt_clr_i    (cnt_clr),
        .accept_cnt_o (accept_cnt),
        .drop_cnt_o   (drop_cnt),
        .runt_cnt_o   (runt_cnt),
        .match_idx_o  (match_idx)
    );

    always #4 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] tx_buf [128];
    int         tx_len = 0;
    int         seed = 0;
    logic       tx_user_last = 1'b0;
    logic       clr_on_last = 1'b0;
    int         ready_low = 0;
    logic [9:0] rx_q [$];
    logic       prev_stall = 1'b0;
    logic [9:0] prev_word = '0;
    logic       rand_done = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: records handshakes and checks that stalled bytes hold.
    always @(negedge clk) begin
        if (prev_stall) begin
            checks++;
            assert ({out_tvalid, out_tuser, out_tlast, out_tdata} === {1'b1, prev_word}) else begin
                failures++;
                $error("FAIL stall_hold observed=%0h expected=%0h",
                       {out_tvalid, out_tuser, out_tlast, out_tdata}, {1'b1, prev_word});
            end
        end
        if (out_tvalid && out_tready) rx_q.push_back({out_tuser, out_tlast, out_tdata});
        prev_stall = out_tvalid && !out_tready;
        prev_word  = {out_tuser, out_tlast, out_tdata};
    end

    task automatic build(input logic [47:0] dest, input int len);
        tx_len = len;
        for (int i = 0; i < 6; i++) tx_buf[i] = dest[47-8*i -: 8];
        for (int i = 6; i < len; i++) tx_buf[i] = 8'(i * 7 + seed);
        seed = seed + 13;
    endtask

    task automatic send_frame();
        logic ready_s;
        int   waited;
        for (int i = 0; i < tx_len; i++) begin
            in_tdata  = tx_buf[i];
            in_tvalid = 1'b1;
            in_tlast  = (i == tx_len - 1);
            in_tuser  = (i == tx_len - 1) ? tx_user_last : 1'b0;
            cnt_clr   = (i == tx_len - 1) ? clr_on_last : 1'b0;
            waited    = 0;
            ready_s   = 1'b0;
            while (!ready_s && waited < 300) begin
                @(negedge clk);
                ready_s = in_tready;
                if (!ready_s) ready_low++;
                @(posedge clk);
                #1;
                waited++;
            end
            if (!ready_s) chk("in_handshake_timeout", {63'd0, ready_s}, 64'd1);
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        in_tuser  = 1'b0;
        cnt_clr   = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int c = 0;
        while (rx_q.size() < n && c < 600) begin
            @(posedge clk);
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_rx(input string tag, input int n);
        chk({tag, "_len"}, 64'(rx_q.size()), 64'(n));
        if (rx_q.size() == n) begin
            for (int i = 0; i < n; i++) begin
                chk({tag, "_data"}, {56'd0, rx_q[i][7:0]}, {56'd0, tx_buf[i]});
                chk({tag, "_last"}, {63'd0, rx_q[i][8]}, {63'd0, (i == n - 1)});
                chk({tag, "_user"}, {63'd0, rx_q[i][9]}, {63'd0, (i == n - 1) & tx_user_last});
            end
        end
    endtask

    task automatic run_frame(input logic [47:0] dest, input int len, input int exp_out);
        rx_q.delete();
        ready_low = 0;
        build(dest, len);
        send_frame();
        wait_rx(exp_out);
    endtask

    initial begin
        mac_table[48*2 +: 48] = 48'h0200_0000_0005;
        mac_table[48*0 +: 48] = 48'h0200_0000_0099;
        mac_valid = 4'b0100;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        chk("rst_out_tvalid", {63'd0, out_tvalid}, 64'd0);
        chk("rst_out_tdata", {56'd0, out_tdata}, 64'd0);
        chk("rst_in_tready", {63'd0, in_tready}, 64'd1);
        chk("rst_counters", {52'd0, accept_cnt, drop_cnt, runt_cnt}, 64'd0);
        chk("rst_match_idx", {60'd0, match_idx}, 64'd0);

        // 64-byte unicast hit on entry 2, tuser set on the final byte
        tx_user_last = 1'b1;
        run_frame(48'h0200_0000_0005, 64, 64);
        check_rx("uc64", 64);
        tx_user_last = 1'b0;
        chk("uc64_accept_cnt", 64'(accept_cnt), 64'd1);
        chk("uc64_match_idx", 64'(match_idx), 64'd2);

        // Unicast miss (entry 0 holds this address but is disabled)
        run_frame(48'h0200_0000_0099, 10, 0);
        check_rx("miss", 0);
        chk("miss_ready_low", 64'(ready_low), 64'd0);
        chk("miss_drop_cnt", 64'(drop_cnt), 64'd1);

        promisc = 1'b1;
        run_frame(48'h0200_0000_0099, 10, 10);
        check_rx("promisc", 10);
        promisc = 1'b0;
        chk("promisc_accept_cnt", 64'(accept_cnt), 64'd2);
        chk("promisc_match_hold", 64'(match_idx), 64'd2);

        // Broadcast off, broadcast on, then multicast-all
        run_frame(48'hFFFF_FFFF_FFFF, 8, 0);
        check_rx("bcast_off", 0);
        chk("bcast_off_drop_cnt", 64'(drop_cnt), 64'd2);
        bcast_en = 1'b1;
        run_frame(48'hFFFF_FFFF_FFFF, 8, 8);
        check_rx("bcast_on", 8);
        bcast_en = 1'b0;
        mcast_all = 1'b1;
        run_frame(48'h0100_5E00_0001, 12, 12);
        check_rx("mcast", 12);
        mcast_all = 1'b0;
        chk("mcast_accept_cnt", 64'(accept_cnt), 64'd4);

        // 4-byte runt, then an intact frame; a 6-byte frame is also a runt
        run_frame(48'h0200_0000_0005, 4, 0);
        check_rx("runt4", 0);
        chk("runt4_runt_cnt", 64'(runt_cnt), 64'd1);
        run_frame(48'h0200_0000_0005, 6, 0);
        check_rx("runt6", 0);
        chk("runt6_runt_cnt", 64'(runt_cnt), 64'd2);
        run_frame(48'h0200_0000_0005, 20, 20);
        check_rx("after_runt", 20);
        chk("after_runt_accept_cnt", 64'(accept_cnt), 64'd5);

        // 20-byte frame with random output backpressure
        rx_q.delete();
        build(48'h0200_0000_0005, 20);
        rand_done = 1'b0;
        fork
            begin
                send_frame();
                wait_rx(20);
                rand_done = 1'b1;
            end
            begin
                for (int c = 0; c < 3000 && !rand_done; c++) begin
                    @(posedge clk);
                    #1;
                    out_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_tready = 1'b1;
        wait_rx(20);
        check_rx("bp20", 20);
        chk("bp20_accept_cnt", 64'(accept_cnt), 64'd6);

        // Drive drop_cnt to saturation, one more drop, then clear on a drop
        for (int f = 0; f < 13; f++) run_frame(48'h0200_0000_0099, 7, 0);
        chk("sat_drop_cnt", 64'(drop_cnt), 64'hF);
        run_frame(48'h0200_0000_0099, 7, 0);
        chk("sat_hold_drop_cnt", 64'(drop_cnt), 64'hF);
        clr_on_last = 1'b1;
        run_frame(48'h0200_0000_0099, 7, 0);
        clr_on_last = 1'b0;
        chk("clr_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("clr_accept_cnt", 64'(accept_cnt), 64'd0);
        chk("clr_runt_cnt", 64'(runt_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
